udm_cmd_decoder: RTL

Decodes the UDM host command byte stream into 32-bit bus requests on the device side. It accepts bytes from the UART receiver and handles framing, escaping and command parsing. It then issues write and read requests with a valid/ack handshake and drives the bus reset level and the ID-code request pulse. It sits between the UART receiver and the bus master / response encoder inside udm.

---
 rtl/udm_pkg.sv | 50 +++++
 rtl/udm_unescape.sv | 32 +++
 rtl/udm_cmd_decoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/udm_pkg.sv
// Shared constants, command codes and FSM states for the UDM host command decoder.
package udm_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] ESC_BYTE  = 8'h5A;

  typedef enum logic [7:0] {
    CMD_IDCODE   = 8'h00,
    CMD_RST      = 8'h80,
    CMD_WR_INC   = 8'h81,
    CMD_RD_INC   = 8'h82,
    CMD_WR_NOINC = 8'h83,
    CMD_RD_NOINC = 8'h84,
    CMD_NRST     = 8'hC0
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_WDATA,
    ST_BUS_WR,
    ST_BUS_RD
  } state_e;

  function automatic logic is_bus_cmd(input logic [7:0] code);
    return (code == CMD_WR_INC) || (code == CMD_RD_INC) ||
           (code == CMD_WR_NOINC) || (code == CMD_RD_NOINC);
  endfunction

  function automatic logic is_write_cmd(input logic [7:0] code);
    return (code == CMD_WR_INC) || (code == CMD_WR_NOINC);
  endfunction

  function automatic logic is_inc_cmd(input logic [7:0] code);
    return (code == CMD_WR_INC) || (code == CMD_RD_INC);
  endfunction

  // Byte enables for a word carrying n valid bytes; n = 4 gives the full word.
  function automatic logic [3:0] be_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/udm_unescape.sv
// Strips the ESC prefix from the received byte stream and flags unescaped SYNC bytes.
module udm_unescape
  import udm_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_sync_det
);

  logic r_esc;

  // The byte after an ESC is always literal, even if it is another ESC or a SYNC.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_esc <= 1'b0;
    end else if (i_rx_valid) begin
      r_esc <= !r_esc && (i_rx_data == ESC_BYTE);
    end
  end

  always_comb begin
    o_byte_data  = i_rx_data;
    o_sync_det   = i_rx_valid && !r_esc && (i_rx_data == SYNC_BYTE);
    o_byte_valid = i_rx_valid &&
                   (r_esc || ((i_rx_data != SYNC_BYTE) && (i_rx_data != ESC_BYTE)));
  end

endmodule

// File: rtl/udm_cmd_decoder.sv
// Parses unescaped UDM host frames into 32-bit bus requests with a valid/ack handshake,
// plus bus reset level, ID-code pulse and sticky overrun/error flags.
module udm_cmd_decoder
  import udm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  output logic        bus_rst_o,
  output logic        idcode_req_o,
  output logic        overrun_o,
  output logic        error_o,
  output logic        busy_o
);

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  state_e      w_nextState;
  logic        w_byteValid;
  logic [7:0]  w_byteData;
  logic        w_sync;
  logic        w_timed;
  logic        w_timeout;
  logic        w_ack;
  logic        w_wordDone;
  logic [2:0]  w_byteCount;
  logic [31:0] w_lenFull;
  logic [31:0] w_rdStep;
  logic [31:0] w_lenAfterRd;

  logic [31:0] r_addr;
  logic [31:0] r_len;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_byteIdx;
  logic        r_write;
  logic        r_inc;
  logic        r_req;
  logic        r_syncPend;
  logic        r_busRst;
  logic        r_idcode;
  logic        r_overrun;
  logic        r_error;
  logic [31:0] r_toCnt;

  udm_unescape u_unescape (
    .i_clk        (clk_i),
    .i_rstn       (rstn_i),
    .i_rx_valid   (rx_valid_i),
    .i_rx_data    (rx_data_i),
    .o_byte_valid (w_byteValid),
    .o_byte_data  (w_byteData),
    .o_sync_det   (w_sync)
  );

  assign w_timed = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                   (r_state == ST_LEN) || (r_state == ST_WDATA);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_timed && !rx_valid_i && (r_toCnt == TO_LAST);
  assign w_ack        = r_req && bus_ack_i;
  assign w_byteCount  = {1'b0, r_byteIdx} + 3'd1;
  assign w_lenFull    = {w_byteData, r_len[31:8]};
  assign w_rdStep     = (r_len >= 32'd4) ? 32'd4 : r_len;
  assign w_lenAfterRd = r_len - w_rdStep;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_wordDone  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sync) w_nextState = ST_CMD;
      end
      ST_CMD: begin
        if (w_sync) w_nextState = ST_CMD;
        else if (w_byteValid) w_nextState = is_bus_cmd(w_byteData) ? ST_ADDR : ST_IDLE;
        else if (w_timeout) w_nextState = ST_IDLE;
      end
      ST_ADDR: begin
        if (w_sync) w_nextState = ST_CMD;
        else if (w_byteValid && (r_byteIdx == 2'd3)) w_nextState = ST_LEN;
        else if (w_timeout) w_nextState = ST_IDLE;
      end
      ST_LEN: begin
        if (w_sync) w_nextState = ST_CMD;
        else if (w_byteValid && (r_byteIdx == 2'd3)) begin
          if (w_lenFull == 32'd0) w_nextState = ST_IDLE;
          else if (r_write) w_nextState = ST_WDATA;
          else w_nextState = ST_BUS_RD;
        end else if (w_timeout) w_nextState = ST_IDLE;
      end
      ST_WDATA: begin
        if (w_sync) w_nextState = ST_CMD;
        else if (w_byteValid &&
                 ((w_byteCount == 3'd4) || (r_len == {29'd0, w_byteCount}))) begin
          w_wordDone  = 1'b1;
          w_nextState = ST_BUS_WR;
        end else if (w_timeout) w_nextState = ST_IDLE;
      end
      ST_BUS_WR: begin
        if (w_ack) begin
          if (r_syncPend || w_sync) w_nextState = ST_CMD;
          else if (r_len == 32'd0) w_nextState = ST_IDLE;
          else w_nextState = ST_WDATA;
        end
      end
      ST_BUS_RD: begin
        // Between reads no request is pending, so a SYNC can leave at once.
        if (w_ack) begin
          if (r_syncPend || w_sync) w_nextState = ST_CMD;
          else if (w_lenAfterRd == 32'd0) w_nextState = ST_IDLE;
        end else if (!r_req && w_sync) begin
          w_nextState = ST_CMD;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_byteIdx  <= '0;
      r_write    <= 1'b0;
      r_inc      <= 1'b0;
      r_req      <= 1'b0;
      r_syncPend <= 1'b0;
      r_busRst   <= 1'b0;
      r_idcode   <= 1'b0;
      r_overrun  <= 1'b0;
      r_error    <= 1'b0;
      r_toCnt    <= '0;
    end else begin
      r_idcode <= 1'b0;
      if (rx_valid_i || !w_timed) r_toCnt <= '0;
      else r_toCnt <= r_toCnt + 32'd1;
      if (w_timeout) r_error <= 1'b1;
      r_syncPend <= ((w_nextState == ST_BUS_WR) || (w_nextState == ST_BUS_RD)) &&
                    (r_syncPend || w_sync);

      case (r_state)
        ST_CMD: begin
          if (w_byteValid) begin
            r_write   <= is_write_cmd(w_byteData);
            r_inc     <= is_inc_cmd(w_byteData);
            r_byteIdx <= 2'd0;
            case (w_byteData)
              CMD_IDCODE: r_idcode <= 1'b1;
              CMD_RST:    r_busRst <= 1'b1;
              CMD_NRST:   r_busRst <= 1'b0;
              default:    if (!is_bus_cmd(w_byteData)) r_error <= 1'b1;
            endcase
          end
        end
        ST_ADDR: begin
          if (w_byteValid) begin
            r_addr    <= {w_byteData, r_addr[31:8]};
            r_byteIdx <= r_byteIdx + 2'd1;
          end
        end
        ST_LEN: begin
          if (w_byteValid) begin
            r_len     <= w_lenFull;
            r_byteIdx <= r_byteIdx + 2'd1;
            if ((r_byteIdx == 2'd3) && (w_lenFull != 32'd0) && !r_write) begin
              r_req <= 1'b1;
              r_be  <= 4'b1111;
            end
          end
        end
        ST_WDATA: begin
          if (w_byteValid) begin
            r_wdata[{r_byteIdx, 3'b000} +: 8] <= w_byteData;
            r_byteIdx <= r_byteIdx + 2'd1;
          end
          if (w_wordDone) begin
            r_req     <= 1'b1;
            r_be      <= be_mask(w_byteCount);
            r_len     <= r_len - {29'd0, w_byteCount};
            r_byteIdx <= 2'd0;
          end
        end
        ST_BUS_WR: begin
          if (w_byteValid) r_overrun <= 1'b1;
          if (w_ack) begin
            r_req   <= 1'b0;
            r_wdata <= '0;
            if (r_inc) r_addr <= r_addr + 32'd4;
          end
        end
        ST_BUS_RD: begin
          if (w_byteValid) r_overrun <= 1'b1;
          if (w_ack) begin
            r_req <= 1'b0;
            r_len <= w_lenAfterRd;
            if (r_inc) r_addr <= r_addr + 32'd4;
          end else if (!r_req && !w_sync) begin
            r_req <= 1'b1;
          end
        end
        default: ;
      endcase

      // Any frame restart or end drops partial collection state.
      if ((w_nextState == ST_CMD) || (w_nextState == ST_IDLE)) begin
        r_byteIdx <= 2'd0;
        r_wdata   <= '0;
      end
    end
  end

  assign bus_req_o    = r_req;
  assign bus_we_o     = r_write && r_req;
  assign bus_addr_o   = {r_addr[31:2], 2'b00};
  assign bus_be_o     = r_be;
  assign bus_wdata_o  = r_wdata;
  assign bus_rst_o    = r_busRst;
  assign idcode_req_o = r_idcode;
  assign overrun_o    = r_overrun;
  assign error_o      = r_error;
  assign busy_o       = (r_state != ST_IDLE);

endmodule
